// File: rtl/a_up_cntr_pkg.sv
// Shared definitions for the free-running up-counter: default width,
// default count type and the next-count function (increment with wrap).
package a_up_cntr_pkg;

    localparam int unsigned CNTR_WIDTH_DEFAULT = 4;

    typedef logic [CNTR_WIDTH_DEFAULT-1:0] cntr_t;

    // Operands are zero-extended to 32 bits by the caller and the result is
    // truncated back to WIDTH, so the add behaves as a WIDTH-bit increment.
    function automatic logic [31:0] cntr_next(input logic [31:0] cur,
                                              input logic [31:0] max_cnt,
                                              input logic [31:0] rst_val);
        return (cur == max_cnt) ? rst_val : cur + 32'd1;
    endfunction

endpackage

// File: rtl/a_up_cntr_chk.sv
// Bind-able checker for a_up_cntr: count stays within range and is held at
// RESET_VALUE while reset is asserted.
module a_up_cntr_chk #(
    parameter int unsigned      WIDTH       = 4,
    parameter longint unsigned  MAX_COUNT   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned  RESET_VALUE = 64'd0
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] count
);

    a_count_in_range: assert property (@(posedge clk) rst |-> (64'(count) <= MAX_COUNT))
        else $error("count %0d exceeds MAX_COUNT %0d", count, MAX_COUNT);

    a_count_held_in_reset: assert property (@(posedge clk) !rst |-> (64'(count) == RESET_VALUE))
        else $error("count %0d not at RESET_VALUE while in reset", count);

endmodule

// File: rtl/a_up_cntr.sv
// Free-running binary up-counter with asynchronous active-low reset; wraps to
// RESET_VALUE after MAX_COUNT. count is driven straight from the register.
module a_up_cntr
    import a_up_cntr_pkg::*;
#(
    parameter int unsigned      WIDTH       = CNTR_WIDTH_DEFAULT,
    parameter longint unsigned  MAX_COUNT   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned  RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "a_up_cntr: WIDTH %0d outside 1..32", WIDTH);
        end
        if (MAX_COUNT < 1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $fatal(1, "a_up_cntr: MAX_COUNT %0d not in 1..2**WIDTH-1", MAX_COUNT);
        end
        if (RESET_VALUE > MAX_COUNT) begin : g_bad_rst
            $fatal(1, "a_up_cntr: RESET_VALUE %0d exceeds MAX_COUNT %0d", RESET_VALUE, MAX_COUNT);
        end
    endgenerate

    localparam logic [31:0] MAX_C = 32'(MAX_COUNT);
    localparam logic [31:0] RST_C = 32'(RESET_VALUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= WIDTH'(RST_C);
        end else begin
            count <= WIDTH'(cntr_next(32'(count), MAX_C, RST_C));
        end
    end

endmodule

// File: tb/tb_a_up_cntr.sv
// Scoreboard bench for a_up_cntr: a default 4-bit counter and a decade
// variant share one clock and are checked each cycle against queued values.
module tb_a_up_cntr;

    typedef struct {
        logic [3:0] c;
        logic [3:0] d;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rst_d;
    logic [3:0] count;
    logic [3:0] count_d;

    exp_t       sb_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] m      = 4'd0;
    logic [3:0] md     = 4'd0;

    a_up_cntr dut (
        .clk   (clk),
        .rst   (rst),
        .count (count)
    );

    a_up_cntr #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0)) dut_dec (
        .clk   (clk),
        .rst   (rst_d),
        .count (count_d)
    );

    a_up_cntr_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (count)
    );

    a_up_cntr_chk #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0)) u_chk_dec (
        .clk   (clk),
        .rst   (rst_d),
        .count (count_d)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] v, input logic [3:0] lim);
        return (v == lim) ? 4'd0 : v + 4'd1;
    endfunction

    // One clock edge: advance the reference values, then queue them.
    task automatic step();
        exp_t e;
        @(posedge clk);
        m  = rst   ? nxt(m, 4'd15) : 4'd0;
        md = rst_d ? nxt(md, 4'd9) : 4'd0;
        #1;
        e.c = m;
        e.d = md;
        sb_q.push_back(e);
    endtask

    // Monitor: sample 3 time units after each edge, clear of stimulus changes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("count", count, e.c);
                chk("count_dec", count_d, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst   = 1'b0;
        rst_d = 1'b0;
        #1;
        chk("por_count", count, 4'd0);
        chk("por_count_dec", count_d, 4'd0);
        repeat (5) step();          // edges 10..90 held in reset
        #9;
        rst   = 1'b1;               // t = 100
        rst_d = 1'b1;
        repeat (5) step();          // edges 110..190 -> 1..5
        #9;
        rst = 1'b0;                 // t = 200, between edges
        #1;
        chk("async_mid_cycle", count, 4'd0);
        repeat (11) step();         // edges 210..410 held at 0
        #4;
        rst = 1'b1;                 // t = 415
        repeat (17) step();         // edges 430..750 -> 1..15, 0, 1
        guard = 0;
        while (md != 4'd7 && guard < 20) begin
            step();
            guard++;
        end
        n_chk++;
        if (md != 4'd7) begin
            n_fail++;
            $display("FAIL dec_reach7: got %0d, expected 7", md);
        end
        #5;
        rst_d = 1'b0;               // decade counter reset while at 7
        #1;
        chk("dec_async_at7", count_d, 4'd0);
        repeat (3) step();
        #4;
        rst_d = 1'b1;
        repeat (3) step();          // decade restarts 1, 2, 3
        @(posedge clk);
        #5;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
